// File: rtl/radar_pkg.sv
// Shared widths, FSM state encoding and SRAM write payload for radar_frame_writer.
package radar_pkg;

  localparam int unsigned SRAM_ADDR_W = 14;
  localparam int unsigned SRAM_DATA_W = 32;
  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned SRAM_BE_W   = SRAM_DATA_W / 8;
  localparam int unsigned FRAME_LEN_W = 13;
  localparam int unsigned OVF_W       = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] address;
    logic [SRAM_DATA_W-1:0] writedata;
    logic [SRAM_BE_W-1:0]   byteenable;
  } sram_wr_t;

endpackage

// File: rtl/radar_sample_packer.sv
// Holds the even (low-half) sample and forms the 32-bit SRAM word plus lane enables.
module radar_sample_packer
  import radar_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   store,
  input  logic                   odd,
  input  logic [SAMPLE_W-1:0]    sample,
  output logic [SRAM_DATA_W-1:0] word_c,
  output logic [SRAM_BE_W-1:0]   be_c
);

  logic [SAMPLE_W-1:0] low_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) low_q <= '0;
    else if (store) low_q <= sample;
  end

  // Odd sample completes the pair; an even sample alone is a half word with upper lanes zero.
  always_comb begin
    word_c = {SAMPLE_W'(0), sample};
    be_c   = SRAM_BE_W'(4'b0011);
    if (odd) begin
      word_c = {sample, low_q};
      be_c   = '1;
    end
  end

endmodule

// File: rtl/radar_frame_writer.sv
// Writes framed 16-bit radar samples into ping-pong SRAM buffers, two samples per word.
// Optional overflow/abort counter on port ovf_count when RADAR_FRAME_WRITER_OVF_CNT_EN is defined.
module radar_frame_writer
  import radar_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   snk_valid,
  output logic                   snk_ready,
  input  logic [SAMPLE_W-1:0]    snk_data,
  input  logic                   snk_sop,
  input  logic                   snk_eop,
  output logic [SRAM_ADDR_W-1:0] sram_address,
  output logic                   sram_chipselect,
  output logic                   sram_write,
  output logic [SRAM_DATA_W-1:0] sram_writedata,
  output logic [SRAM_BE_W-1:0]   sram_byteenable,
  output logic                   sram_clken,
  output logic                   frame_done,
  output logic                   frame_buf,
  output logic [FRAME_LEN_W-1:0] frame_len
`ifdef RADAR_FRAME_WRITER_OVF_CNT_EN
  ,
  output logic [OVF_W-1:0]       ovf_count
`endif
);

  // Word index must be able to hold FRAME_WORDS itself to flag a full buffer.
  localparam int unsigned IDX_W = SRAM_ADDR_W;

  state_e                 state_q, state_d;
  logic                   cur_buf_q, cur_buf_d;
  logic [IDX_W-1:0]       word_idx_q, word_idx_d;
  logic                   odd_q, odd_d;
  logic                   ready_q, ready_d;
  logic                   wr_q, wr_d;
  sram_wr_t               wr_pl_q, wr_pl_d;
  logic                   done_q, done_d;
  logic                   fbuf_q, fbuf_d;
  logic [FRAME_LEN_W-1:0] flen_q, flen_d;

  logic                   xfer_c, full_c, store_c, pk_odd_c;
  logic [IDX_W-1:0]       wr_idx_c;
  logic [SRAM_ADDR_W-1:0] buf_base_c;
  logic [SRAM_DATA_W-1:0] word_c;
  logic [SRAM_BE_W-1:0]   be_c;

  assign xfer_c     = snk_valid && ready_q;
  assign full_c     = (word_idx_q == IDX_W'(FRAME_WORDS));
  assign buf_base_c = SRAM_ADDR_W'(BASE_ADDR) +
                      (cur_buf_q ? SRAM_ADDR_W'(FRAME_WORDS) : SRAM_ADDR_W'(0));

  radar_sample_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .store   (store_c),
    .odd     (pk_odd_c),
    .sample  (snk_data),
    .word_c  (word_c),
    .be_c    (be_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cur_buf_q  <= 1'b0;
      word_idx_q <= '0;
      odd_q      <= 1'b0;
      ready_q    <= 1'b0;
      wr_q       <= 1'b0;
      wr_pl_q    <= '0;
      done_q     <= 1'b0;
      fbuf_q     <= 1'b0;
      flen_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_buf_q  <= cur_buf_d;
      word_idx_q <= word_idx_d;
      odd_q      <= odd_d;
      ready_q    <= ready_d;
      wr_q       <= wr_d;
      wr_pl_q    <= wr_pl_d;
      done_q     <= done_d;
      fbuf_q     <= fbuf_d;
      flen_q     <= flen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_buf_d  = cur_buf_q;
    word_idx_d = word_idx_q;
    odd_d      = odd_q;
    wr_d       = 1'b0;
    wr_pl_d    = wr_pl_q;
    done_d     = 1'b0;
    fbuf_d     = fbuf_q;
    flen_d     = flen_q;
    store_c    = 1'b0;
    pk_odd_c   = 1'b0;
    wr_idx_c   = word_idx_q;
    ready_d    = 1'b0;

    case (state_q)
      S_IDLE, S_FILL: begin
        // A sop starts (or in FILL restarts) a frame at word 0 of the current buffer.
        if (xfer_c && snk_sop && (enable || state_q == S_FILL)) begin
          wr_idx_c   = '0;
          word_idx_d = '0;
          store_c    = 1'b1;
          odd_d      = 1'b1;
          state_d    = S_FILL;
          if (snk_eop) begin
            wr_d       = 1'b1;
            word_idx_d = IDX_W'(1);
            odd_d      = 1'b0;
            state_d    = S_DONE;
          end
        end else if (xfer_c && state_q == S_FILL) begin
          if (full_c) begin
            if (snk_eop) state_d = S_DONE;
          end else if (odd_q) begin
            wr_d       = 1'b1;
            pk_odd_c   = 1'b1;
            word_idx_d = word_idx_q + IDX_W'(1);
            odd_d      = 1'b0;
            if (snk_eop) state_d = S_DONE;
          end else if (snk_eop) begin
            wr_d       = 1'b1;
            word_idx_d = word_idx_q + IDX_W'(1);
            state_d    = S_DONE;
          end else begin
            store_c = 1'b1;
            odd_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d     = 1'b1;
        fbuf_d     = cur_buf_q;
        flen_d     = FRAME_LEN_W'(word_idx_q);
        cur_buf_d  = ~cur_buf_q;
        word_idx_d = '0;
        odd_d      = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_d) begin
      wr_pl_d.address    = buf_base_c + wr_idx_c;
      wr_pl_d.writedata  = word_c;
      wr_pl_d.byteenable = be_c;
    end

    case (state_d)
      S_IDLE:  ready_d = enable;
      S_FILL:  ready_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  assign snk_ready       = ready_q;
  assign sram_chipselect = wr_q;
  assign sram_write      = wr_q;
  assign sram_address    = wr_pl_q.address;
  assign sram_writedata  = wr_pl_q.writedata;
  assign sram_byteenable = wr_pl_q.byteenable;
  assign sram_clken      = 1'b1;
  assign frame_done      = done_q;
  assign frame_buf       = fbuf_q;
  assign frame_len       = flen_q;

`ifdef RADAR_FRAME_WRITER_OVF_CNT_EN
  // Dropped samples past a full buffer and sop-aborted frames, saturating.
  logic             ovf_inc_c;
  logic [OVF_W-1:0] ovf_q;

  assign ovf_inc_c = xfer_c && (state_q == S_FILL) && (snk_sop || full_c);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= '0;
    else if (ovf_inc_c && (ovf_q != '1)) ovf_q <= ovf_q + OVF_W'(1);
  end

  assign ovf_count = ovf_q;
`endif

endmodule

// File: tb/tb_radar_frame_writer.sv
// Self-checking bench for radar_frame_writer: table vectors, corner sequences and random frames.
module tb_radar_frame_writer;

  localparam int unsigned FW = 4;
  localparam int unsigned BA = 0;

  logic        clk = 1'b0;
  logic        reset_n, enable, snk_valid, snk_ready, snk_sop, snk_eop;
  logic [15:0] snk_data;
  logic [13:0] sram_address;
  logic        sram_chipselect, sram_write, sram_clken, frame_done, frame_buf;
  logic [31:0] sram_writedata;
  logic [3:0]  sram_byteenable;
  logic [12:0] frame_len;
`ifdef RADAR_FRAME_WRITER_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  radar_frame_writer #(.BASE_ADDR(BA), .FRAME_WORDS(FW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .snk_valid       (snk_valid),
    .snk_ready       (snk_ready),
    .snk_data        (snk_data),
    .snk_sop         (snk_sop),
    .snk_eop         (snk_eop),
    .sram_address    (sram_address),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_writedata  (sram_writedata),
    .sram_byteenable (sram_byteenable),
    .sram_clken      (sram_clken),
    .frame_done      (frame_done),
    .frame_buf       (frame_buf),
    .frame_len       (frame_len)
`ifdef RADAR_FRAME_WRITER_OVF_CNT_EN
    ,
    .ovf_count       (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [13:0] a; logic [31:0] d; logic [3:0] be; int cyc; } wr_t;
  typedef struct { bit b; int len; int cyc; } done_t;
  typedef struct {
    int n; logic [15:0] first; int exp_len; bit exp_buf;
    logic [13:0] la; logic [31:0] ld; logic [3:0] lbe; int ovf_inc;
  } vec_t;

  wr_t   wq[$];
  wr_t   ew[$];
  done_t dq[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    mbuf = 1'b0;
  int    movf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Capture every SRAM write and frame_done pulse between clock edges.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sram_write || sram_chipselect) begin
        check("cs_eq_write", 32'(sram_chipselect), 32'(sram_write));
        wq.push_back('{a: sram_address, d: sram_writedata, be: sram_byteenable, cyc: cyc});
      end
      if (frame_done) dq.push_back('{b: frame_buf, len: int'(frame_len), cyc: cyc});
    end
  end

  task automatic add_ovf(input int k);
    movf = (movf + k > 65535) ? 65535 : movf + k;
  endtask

  task automatic check_ovf();
`ifdef RADAR_FRAME_WRITER_OVF_CNT_EN
    check("ovf_count", 32'(ovf_count), 32'(movf));
`endif
  endtask

  // Expected writes from the packing rules: pairs up to FW words, optional trailing half word.
  task automatic model_frame(input logic [15:0] s[$], input bit b, output int len, output int drop);
    int n, pairs, full;
    bit half;
    n = s.size();
    pairs = n / 2;
    full = (pairs < int'(FW)) ? pairs : int'(FW);
    half = (n % 2 == 1) && (pairs < int'(FW));
    ew.delete();
    for (int j = 0; j < full; j++)
      ew.push_back('{a: 14'(BA + b * FW + j), d: {s[2*j+1], s[2*j]}, be: 4'hF, cyc: 0});
    if (half) ew.push_back('{a: 14'(BA + b * FW + pairs), d: {16'h0000, s[n-1]}, be: 4'h3, cyc: 0});
    len = ew.size();
    drop = n - 2 * full - (half ? 1 : 0);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [15:0] d, input bit s, input bit e);
    int n = 0;
    snk_valid = 1'b1; snk_data = d; snk_sop = s; snk_eop = e;
    while (!snk_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: got ready=0 for 50 cycles expected 1");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int t = 0;
    while (dq.size() == 0 && t < 40) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] s[$], input bit drop_en, input bit gaps);
    int len, drop, m;
    model_frame(s, mbuf, len, drop);
    wq.delete(); dq.delete();
    for (int i = 0; i < s.size(); i++) begin
      if (gaps) begin
        snk_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      send(s[i], i == 0, i == s.size() - 1);
      if (drop_en && i == 0) enable = 1'b0;
    end
    snk_valid = 1'b0;
    wait_done();
    check("n_writes", 32'(wq.size()), 32'(ew.size()));
    m = (wq.size() < ew.size()) ? wq.size() : ew.size();
    for (int k = 0; k < m; k++) begin
      check("wr_addr", 32'(wq[k].a), 32'(ew[k].a));
      check("wr_data", wq[k].d, ew[k].d);
      check("wr_be", 32'(wq[k].be), 32'(ew[k].be));
    end
    check("n_done", 32'(dq.size()), 32'd1);
    if (dq.size() > 0) begin
      check("frame_buf", 32'(dq[0].b), 32'(mbuf));
      check("frame_len", 32'(dq[0].len), 32'(len));
      if (drop == 0 && wq.size() > 0)
        check("done_latency", 32'(dq[0].cyc - wq[wq.size()-1].cyc), 32'd1);
    end
    mbuf = ~mbuf;
    add_ovf(drop);
    check_ovf();
    enable = 1'b1;
  endtask

  task automatic check_reset_outs();
    check("rst_ready", 32'(snk_ready), 32'd0);
    check("rst_write", 32'(sram_write), 32'd0);
    check("rst_cs", 32'(sram_chipselect), 32'd0);
    check("rst_addr", 32'(sram_address), 32'd0);
    check("rst_wdata", sram_writedata, 32'd0);
    check("rst_be", 32'(sram_byteenable), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_fbuf", 32'(frame_buf), 32'd0);
    check("rst_flen", 32'(frame_len), 32'd0);
    check("rst_clken", 32'(sram_clken), 32'd1);
    check_ovf();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    vec_t        vec[5];
    logic [15:0] s[$];
    int          n;

    vec[0] = '{8,  16'h0001, 4, 1'b0, 14'd3, 32'h0008_0007, 4'hF, 0};
    vec[1] = '{8,  16'h0001, 4, 1'b1, 14'd7, 32'h0008_0007, 4'hF, 0};
    vec[2] = '{8,  16'h0001, 4, 1'b0, 14'd3, 32'h0008_0007, 4'hF, 0};
    vec[3] = '{10, 16'h0020, 4, 1'b1, 14'd7, 32'h0027_0026, 4'hF, 2};
    vec[4] = '{5,  16'h000A, 3, 1'b0, 14'd2, 32'h0000_000E, 4'h3, 0};

    reset_n = 1'b0; enable = 1'b1; snk_valid = 1'b0;
    snk_data = '0; snk_sop = 1'b0; snk_eop = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs();
    reset_n = 1'b1;

    // Table vectors: fixed frames with known last write and frame length.
    for (int v = 0; v < 5; v++) begin
      int ovf_before;
      ovf_before = movf;
      s.delete();
      for (int i = 0; i < vec[v].n; i++) s.push_back(vec[v].first + 16'(i));
      run_frame(s, 1'b0, 1'b0);
      check("tbl_len", (dq.size() > 0) ? 32'(dq[0].len) : 32'hFFFF_FFFF, 32'(vec[v].exp_len));
      check("tbl_buf", (dq.size() > 0) ? 32'(dq[0].b) : 32'hFFFF_FFFF, 32'(vec[v].exp_buf));
      if (wq.size() > 0) begin
        check("tbl_last_addr", 32'(wq[wq.size()-1].a), 32'(vec[v].la));
        check("tbl_last_data", wq[wq.size()-1].d, vec[v].ld);
        check("tbl_last_be", 32'(wq[wq.size()-1].be), 32'(vec[v].lbe));
      end
      check("tbl_ovf_delta", 32'(movf - ovf_before), 32'(vec[v].ovf_inc));
    end

    // sop on the third sample aborts the frame and restarts at word 0 of the same buffer.
    wq.delete(); dq.delete();
    send(16'h0100, 1'b1, 1'b0);
    send(16'h0101, 1'b0, 1'b0);
    snk_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_pre_writes", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) begin
      check("abort_pre_addr", 32'(wq[0].a), 32'(BA + mbuf * FW));
      check("abort_pre_data", wq[0].d, 32'h0101_0100);
    end
    add_ovf(1);
    s.delete();
    for (int i = 0; i < 8; i++) s.push_back(16'h0200 + 16'(i));
    check("abort_no_done", 32'(dq.size()), 32'd0);
    run_frame(s, 1'b0, 1'b0);

    // enable low keeps snk_ready low in IDLE.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("enable_blocks", 32'(snk_ready), 32'd0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("enable_ready", 32'(snk_ready), 32'd1);

    // Enable dropped mid-frame does not abort; also moves cur_buf to 1 before the reset test.
    s.delete();
    for (int i = 0; i < 7; i++) s.push_back(16'h0300 + 16'(i));
    run_frame(s, 1'b1, 1'b1);

    // Reset in the middle of a frame, right while a write strobe is up.
    wq.delete(); dq.delete();
    send(16'h0400, 1'b1, 1'b0);
    send(16'h0401, 1'b0, 1'b0);
    check("pre_reset_write", 32'(sram_write), 32'd1);
    snk_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    movf = 0;
    check_reset_outs();
    @(negedge clk);
    reset_n = 1'b1;
    mbuf = 1'b0;
    s.delete();
    for (int i = 0; i < 4; i++) s.push_back(16'h0500 + 16'(i));
    run_frame(s, 1'b0, 1'b0);

    // Random frames with gaps, IDLE garbage and mid-frame enable drops.
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        send(16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        snk_valid = 1'b0;
      end
      n = $urandom_range(1, 12);
      s.delete();
      for (int i = 0; i < n; i++) s.push_back(16'($urandom));
      run_frame(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/radar_frame_writer.md
RADAR_FRAME_WRITER -- requirements
Module: radar_frame_writer

Interface
REQ-001 Parameter BASE_ADDR, default 0, word address of ping-pong buffer 0 in on-chip SRAM port 2.
REQ-002 Parameter FRAME_WORDS, default 4096, 32-bit words per buffer; buffer 1 starts at BASE_ADDR+FRAME_WORDS; 2*FRAME_WORDS+BASE_ADDR SHALL be <= 16384.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  level; when low, no new frame is accepted.
REQ-006 snk_valid / snk_ready  in / out  1 / 1  sample-stream handshake; a transfer occurs when both are high.
REQ-007 snk_data  in  16  signed radar sample.
REQ-008 snk_sop / snk_eop  in  1 / 1  frame start / frame end markers, qualified by the transfer.
REQ-009 sram_address  out  14  word address to SRAM port 2.
REQ-010 sram_chipselect, sram_write  out  1 each  single-cycle write strobe, both high together.
REQ-011 sram_writedata / sram_byteenable  out  32 / 4  packed samples / lane enables.
REQ-012 sram_clken  out  1  held high.
REQ-013 frame_done  out  1  one-cycle pulse per completed frame.
REQ-014 frame_buf  out  1  index of the buffer last completed, valid from frame_done onward.
REQ-015 frame_len  out  13  words written in the last completed frame, latched with frame_done.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, DONE.
REQ-017 IDLE: snk_ready = enable. A transfer with snk_sop and enable high SHALL store the sample in the low half, clear word_idx, and go to FILL. Transfers without sop SHALL be accepted and discarded.
REQ-018 FILL: snk_ready SHALL be 1, because SRAM writes are single-cycle with no waitrequest.
REQ-019 Packing: even samples go to [15:0] and odd samples to [31:16]. Each odd sample SHALL issue one write the same cycle: byteenable 1111, address = BASE_ADDR + cur_buf*FRAME_WORDS + word_idx. word_idx then increments.
REQ-020 eop on an even sample SHALL write that word with byteenable 0011 and [31:16]=0.
REQ-021 eop SHALL move the FSM to DONE.
REQ-022 When word_idx reaches FRAME_WORDS before eop, further samples SHALL be accepted and dropped (no write), and the frame SHALL close on eop.
REQ-023 sop received in FILL SHALL abort the current frame without frame_done and restart at word 0 of the same buffer with that sample.
REQ-024 DONE lasts exactly one cycle with snk_ready=0. In DONE: frame_done=1, frame_buf=cur_buf, frame_len=words written. cur_buf toggles, then the FSM returns to IDLE.
REQ-025 Write-to-done latency: frame_done SHALL assert exactly one cycle after the final SRAM write.
REQ-026 Deasserting enable mid-FILL SHALL NOT abort the frame; it only blocks the next sop in IDLE.
REQ-027 sram_write/chipselect SHALL be low in every cycle without a write.

Reset
REQ-028 reset_n low SHALL immediately force: state IDLE, cur_buf 0, word_idx 0, snk_ready 0, sram_write/chipselect 0, sram_address 0, sram_writedata 0, sram_byteenable 0, frame_done 0, frame_buf 0, frame_len 0.
REQ-029 Reset mid-frame SHALL discard the partial frame with no frame_done; sram_clken SHALL be 1 even in reset.

Configuration
REQ-030 Macro RADAR_FRAME_WRITER_OVF_CNT_EN defined: add output ovf_count (16, out). It counts samples dropped per REQ-022 plus frames aborted per REQ-023, saturates at 0xFFFF, and clears on reset. Undefined: the port and the counter are absent, and all other behaviour is identical.

Structure
REQ-031 Package radar_pkg SHALL hold the FSM state enum, SRAM_ADDR_W=14, SRAM_DATA_W=32, and SAMPLE_W=16.
REQ-032 One sub-module, radar_sample_packer, SHALL perform the 16-to-32 packing and byteenable generation; the FSM and addressing stay in the top module.

Verification
REQ-033 FRAME_WORDS=4: frame of 8 samples 0x0001..0x0008 -> writes to addresses 0..3 of 0x00020001, 0x00040003, 0x00060005, 0x00080007 with BE 1111; frame_done one cycle after the last write; frame_buf=0, frame_len=4.
REQ-034 Second 8-sample frame -> addresses 4..7, frame_buf=1; a third frame -> addresses 0..3 again.
REQ-035 5-sample frame 0xA..0xE -> last write at address 2 = 0x0000000E with BE 0011; frame_len=3.
REQ-036 FRAME_WORDS=4 with a 10-sample frame -> 4 writes only, frame_len=4; with the macro defined, ovf_count=2.
REQ-037 sop at sample 3 of a frame -> no frame_done; the new frame overwrites from word 0 of the same buffer; with the macro defined, ovf_count increments by 1.
REQ-038 reset_n pulsed low mid-FILL -> all outputs at reset values asynchronously; the next frame writes buffer 0, word 0.
